// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-ASCII serializer slice.
package bcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HUND = 3'd1,
      ST_TENS = 3'd2,
      ST_ONES = 3'd3,
      ST_TERM = 3'd4
   } state_e;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   function automatic logic digit_bad(input logic [3:0] d);
      return d > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit2ascii.sv
// Combinational conversion of one BCD digit to its ASCII character.
module bcd_digit2ascii
   import bcd_pkg::*;
#(
   parameter logic [7:0] ERR_CHAR = 8'h3F
) (
   input  logic [3:0] digit,
   output logic [7:0] ascii,
   output logic       err
);

   always_comb begin
      err   = digit_bad(digit);
      ascii = err ? ERR_CHAR : ASCII_ZERO + {4'h0, digit};
   end

endmodule

// File: rtl/bcd_ascii_ser.sv
// Serializes a captured 3-digit BCD record into ASCII bytes, MSD first.
// Optional BCD_ASCII_SER_LZ_SUPPRESS_EN drops leading zero digits.
module bcd_ascii_ser
   import bcd_pkg::*;
#(
   parameter logic [7:0] TERMINATOR  = 8'h0A,
   parameter bit         APPEND_TERM = 1'b1,
   parameter logic [7:0] ERR_CHAR    = 8'h3F
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       IN_VALID,
   output logic       IN_READY,
   input  logic [3:0] HUNDREDS,
   input  logic [3:0] TENS,
   input  logic [3:0] ONES,
   output logic [7:0] OUT_DATA,
   output logic       OUT_VALID,
   input  logic       OUT_READY,
   output logic       OUT_LAST,
   output logic       DIGIT_ERR
);

   state_e     state_q, state_d, first_st;
   logic [3:0] tens_q, tens_d, ones_q, ones_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_valid_q, out_valid_d;
   logic       out_last_q, out_last_d;
   logic       digit_err_q, digit_err_d;
   logic [3:0] mux_digit;
   logic [7:0] cvt_byte;
   logic       cvt_err;
   logic       capture, consume;

   assign IN_READY  = (state_q == ST_IDLE) && !RESET;
   assign capture   = IN_VALID && IN_READY;
   assign consume   = out_valid_q && OUT_READY;
   assign OUT_DATA  = out_data_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_LAST  = out_last_q;
   assign DIGIT_ERR = digit_err_q;

   always_comb begin
`ifdef BCD_ASCII_SER_LZ_SUPPRESS_EN
      if (HUNDREDS != 4'd0)  first_st = ST_HUND;
      else if (TENS != 4'd0) first_st = ST_TENS;
      else                   first_st = ST_ONES;
`else
      first_st = ST_HUND;
`endif
   end

   // The converter always looks at the digit of the byte to be loaded next,
   // so the registered OUT_DATA is ready one cycle after capture/consume.
   always_comb begin
      case (state_q)
         ST_IDLE: begin
            case (first_st)
               ST_HUND: mux_digit = HUNDREDS;
               ST_TENS: mux_digit = TENS;
               default: mux_digit = ONES;
            endcase
         end
         ST_HUND: mux_digit = tens_q;
         default: mux_digit = ones_q;
      endcase
   end

   bcd_digit2ascii #(.ERR_CHAR(ERR_CHAR)) u_cvt (
      .digit (mux_digit),
      .ascii (cvt_byte),
      .err   (cvt_err)
   );

   always_comb begin
      state_d     = state_q;
      tens_d      = tens_q;
      ones_d      = ones_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      digit_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (capture) begin
               state_d     = first_st;
               tens_d      = TENS;
               ones_d      = ONES;
               out_valid_d = 1'b1;
               out_data_d  = cvt_byte;
               out_last_d  = (first_st == ST_ONES) && !APPEND_TERM;
               digit_err_d = cvt_err | digit_bad(HUNDREDS) | digit_bad(TENS) | digit_bad(ONES);
            end
         end
         ST_HUND: begin
            if (consume) begin
               state_d    = ST_TENS;
               out_data_d = cvt_byte;
            end
         end
         ST_TENS: begin
            if (consume) begin
               state_d    = ST_ONES;
               out_data_d = cvt_byte;
               out_last_d = !APPEND_TERM;
            end
         end
         ST_ONES: begin
            if (consume) begin
               if (APPEND_TERM) begin
                  state_d    = ST_TERM;
                  out_data_d = TERMINATOR;
                  out_last_d = 1'b1;
               end else begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end
            end
         end
         ST_TERM: begin
            if (consume) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         tens_q      <= '0;
         ones_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         digit_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         digit_err_q <= digit_err_d;
      end
   end

endmodule
